mem_port_arbiter: RTL and testbench

Arbitrates the single word-wide main-memory port of the cached CPU between instruction-cache and data-cache misses. Each miss is served as a 4-word line fill, and a data-side store is served as a single-word write-through. While a requester is waiting, the block drives the pipeline stall lines (`stall_if`, `stall_mem`) so that the pipeline registers hold their contents. Grants are non-preemptive, and the data side has fixed priority.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one word-wide memory port between I-cache and D-cache misses.
// Fills move 4-word lines; D-side stores are single-word write-throughs.
module mem_port_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [63:0] i_line,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [63:0] d_line,
  output logic        d_done,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [2:0] {IDLE, I_FILL, D_FILL, D_WRITE, DONE} state_t;

  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  state_t      state;
  logic        owner_d;
  logic [15:0] line_addr;
  logic [1:0]  word_idx;
  logic [3:0]  lat_cnt;
  logic [1:0]  next_idx;
  logic        last_lat;

  assign next_idx = word_idx + 2'd1;
  assign last_lat = (lat_cnt == LAT_LAST);

  // Stalls must drop in the same cycle as done, so they bypass the registers.
  assign stall_if  = i_req & ~i_done;
  assign stall_mem = d_req & ~d_done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      line_addr <= '0;
      word_idx  <= '0;
      lat_cnt   <= '0;
      i_line    <= '0;
      d_line    <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          word_idx <= '0;
          lat_cnt  <= '0;
          if (d_req) begin
            owner_d <= 1'b1;
            if (d_we) begin
              state     <= D_WRITE;
              line_addr <= d_addr;
              mem_wr    <= 1'b1;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              state     <= D_FILL;
              line_addr <= d_addr & 16'hFFFC;
              mem_rd    <= 1'b1;
              mem_addr  <= d_addr & 16'hFFFC;
            end
          end else if (i_req) begin
            owner_d   <= 1'b0;
            state     <= I_FILL;
            line_addr <= i_addr & 16'hFFFC;
            mem_rd    <= 1'b1;
            mem_addr  <= i_addr & 16'hFFFC;
          end
        end
        I_FILL, D_FILL: begin
          if (last_lat) begin
            lat_cnt  <= '0;
            word_idx <= next_idx;
            if (state == I_FILL) i_line[{word_idx, 4'b0000} +: 16] <= mem_rdata;
            else                 d_line[{word_idx, 4'b0000} +: 16] <= mem_rdata;
            if (word_idx == 2'd3) begin
              state    <= DONE;
              mem_rd   <= 1'b0;
              mem_addr <= '0;
            end else begin
              mem_addr <= line_addr | {14'b0, next_idx};
            end
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        D_WRITE: begin
          if (last_lat) begin
            state     <= DONE;
            lat_cnt   <= '0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        DONE: begin
          // Requests are deliberately not sampled here; done lands in the IDLE cycle.
          state <= IDLE;
          if (owner_d) d_done <= 1'b1;
          else         i_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 runs LATENCY=4, instance 1 LATENCY=1.
// Memory model returns addr ^ 16'h5A5A combinationally.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        i_req     [2];
  logic [15:0] i_addr    [2];
  logic [63:0] i_line    [2];
  logic        i_done    [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [15:0] d_addr    [2];
  logic [15:0] d_wdata   [2];
  logic [63:0] d_line    [2];
  logic        d_done    [2];
  logic        mem_rd    [2];
  logic        mem_wr    [2];
  logic [15:0] mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic        stall_if  [2];
  logic        stall_mem [2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_i [2];
  logic [63:0] exp_d [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(.LATENCY(g == 0 ? 4 : 1)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_req     (i_req[g]),
      .i_addr    (i_addr[g]),
      .i_line    (i_line[g]),
      .i_done    (i_done[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_line    (d_line[g]),
      .d_done    (d_done[g]),
      .mem_rd    (mem_rd[g]),
      .mem_wr    (mem_wr[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .stall_if  (stall_if[g]),
      .stall_mem (stall_mem[g])
    );
    assign mem_rdata[g] = mem_addr[g] ^ 16'h5A5A;
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs(input int k);
    i_req[k] = 0; i_addr[k] = '0; d_req[k] = 0; d_we[k] = 0;
    d_addr[k] = '0; d_wdata[k] = '0;
  endtask

  task automatic check_quiet(input string name, input int k);
    check({name, "_strobes"}, {62'b0, mem_rd[k], mem_wr[k]}, 64'd0);
    check({name, "_bus"}, {32'b0, mem_addr[k], mem_wdata[k]}, 64'd0);
  endtask

  // One transaction from a single requester; starts at #1 after an edge.
  task automatic run_txn(input int k, input logic is_d, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input int exp_done, input logic [63:0] exp_line);
    int lat;
    int acc;
    int got;
    logic [15:0] base;
    logic [33:0] exp_bus;
    lat  = (k == 0) ? 4 : 1;
    acc  = we ? lat : 4 * lat;
    base = we ? addr : (addr & 16'hFFFC);
    got  = -1;
    if (is_d) begin
      d_req[k] = 1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      i_req[k] = 1; i_addr[k] = addr;
    end
    for (int e = 0; e < 100; e++) begin
      step();
      if (e == 0) begin
        i_addr[k] = ~addr; d_addr[k] = ~addr; d_wdata[k] = ~wdata;
      end
      check("other_done", {63'b0, is_d ? i_done[k] : d_done[k]}, 64'd0);
      if (is_d ? d_done[k] : i_done[k]) begin
        got = e;
        break;
      end
      check("stall_wait", {63'b0, is_d ? stall_mem[k] : stall_if[k]}, 64'd1);
      if (e < acc) begin
        exp_bus = {~we, we, base + 16'(e / lat), we ? wdata : 16'h0000};
        check("bus_cycle", {30'b0, mem_rd[k], mem_wr[k], mem_addr[k], mem_wdata[k]},
              {30'b0, exp_bus});
      end else begin
        check_quiet("done_state", k);
      end
    end
    check("done_edge", 64'(got), 64'(exp_done));
    check("stall_drop", {63'b0, is_d ? stall_mem[k] : stall_if[k]}, 64'd0);
    check_quiet("done_cycle", k);
    if (!we) begin
      if (is_d) exp_d[k] = exp_line;
      else      exp_i[k] = exp_line;
    end
    check("i_line", i_line[k], exp_i[k]);
    check("d_line", d_line[k], exp_d[k]);
    clear_inputs(k);
    step();
    check("idle_done", {62'b0, i_done[k], d_done[k]}, 64'd0);
    check_quiet("idle_after", k);
  endtask

  typedef struct {
    int          k;
    logic        is_d;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          done_edge;
    logic [63:0] line;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int dg;
    int ig;
    vecs[0] = '{0, 1'b0, 1'b0, 16'h0103, 16'h0000, 17, {16'h5B59, 16'h5B58, 16'h5B5B, 16'h5B5A}};
    vecs[1] = '{0, 1'b1, 1'b0, 16'h0081, 16'h0000, 17, {16'h5AD9, 16'h5AD8, 16'h5ADB, 16'h5ADA}};
    vecs[2] = '{0, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 5,  64'd0};
    vecs[3] = '{1, 1'b0, 1'b0, 16'h2222, 16'h0000, 5,  {16'h7879, 16'h7878, 16'h787B, 16'h787A}};
    vecs[4] = '{1, 1'b1, 1'b1, 16'h00FF, 16'h1357, 2,  64'd0};
    vecs[5] = '{1, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 5,  {16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6}};

    for (int k = 0; k < 2; k++) begin
      clear_inputs(k);
      exp_i[k] = '0;
      exp_d[k] = '0;
    end
    reset_n = 0;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      check("reset_lines", i_line[k] | d_line[k], 64'd0);
      check("reset_done", {62'b0, i_done[k], d_done[k]}, 64'd0);
      check_quiet("reset", k);
    end
    reset_n = 1;
    step();

    // Simultaneous I and D fill requests: D wins, I follows after the IDLE cycle.
    i_req[0] = 1; i_addr[0] = 16'h0200;
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 16'h0040;
    dg = -1;
    ig = -1;
    for (int e = 0; e < 60; e++) begin
      step();
      if (e == 0) d_addr[0] = 16'hAAAA;
      if (e == 18) begin
        check("sim_i_grant", {47'b0, mem_rd[0], mem_addr[0]}, {47'b0, 1'b1, 16'h0200});
        i_addr[0] = 16'h5555;
      end
      if (d_done[0] && dg < 0) begin
        dg = e;
        d_req[0] = 0;
        check("sim_d_line", d_line[0], {16'h5A19, 16'h5A18, 16'h5A1B, 16'h5A1A});
        check_quiet("sim_gap", 0);
      end
      if (i_done[0]) begin
        ig = e;
        break;
      end
      check("sim_stall_if", {63'b0, stall_if[0]}, 64'd1);
    end
    check("sim_d_done_edge", 64'(dg), 64'd17);
    check("sim_i_done_edge", 64'(ig), 64'd35);
    exp_i[0] = {16'h5859, 16'h5858, 16'h585B, 16'h585A};
    exp_d[0] = {16'h5A19, 16'h5A18, 16'h5A1B, 16'h5A1A};
    check("sim_i_line", i_line[0], exp_i[0]);
    clear_inputs(0);
    step();

    for (int v = 0; v < 6; v++)
      run_txn(vecs[v].k, vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata,
              vecs[v].done_edge, vecs[v].line);

    // Reset during word 2 of an I fill, with i_req held through it.
    i_req[0] = 1; i_addr[0] = 16'h0300;
    for (int e = 0; e < 10; e++) begin
      step();
      check("rst_no_done", {63'b0, i_done[0]}, 64'd0);
      if (e == 8) check("rst_word2_addr", {48'b0, mem_addr[0]}, 64'h0302);
      if (e == 9) reset_n = 0;
    end
    step();
    for (int k = 0; k < 2; k++) begin
      check("rst_mid_lines", i_line[k] | d_line[k], 64'd0);
      check("rst_mid_done", {62'b0, i_done[k], d_done[k]}, 64'd0);
      check_quiet("rst_mid", k);
      exp_i[k] = '0;
      exp_d[k] = '0;
    end
    check("rst_stall_if", {63'b0, stall_if[0]}, 64'd1);
    reset_n = 1;
    ig = -1;
    for (int e = 11; e < 80; e++) begin
      step();
      if (e == 11) check("rst_regrant", {47'b0, mem_rd[0], mem_addr[0]}, {47'b0, 1'b1, 16'h0300});
      if (i_done[0]) begin
        ig = e;
        break;
      end
    end
    check("rst_done_edge", 64'(ig), 64'd28);
    check("rst_i_line", i_line[0], {16'h5959, 16'h5958, 16'h595B, 16'h595A});
    clear_inputs(0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
